// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID boot checker.
// The checker reads the ID word and the timestamp word and compares each with a build-time constant.
package sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } sysid_state_e;

    localparam logic SYSID_WORD_ID = 1'b0;
    localparam logic SYSID_WORD_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h50FF_598A;

    // A word that was never captured can never count as matching.
    function automatic logic word_ok(input logic captured, input logic [31:0] value,
                                     input logic [31:0] expected);
        return captured && (value == expected);
    endfunction

endpackage

// File: rtl/sysid_boot_checker_if.sv
// Avalon-MM read-only link between the boot checker (master) and the sysid slave.
interface sysid_boot_checker_if;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sysid_timeout_ctr.sv
// Loadable up-counter for the read-response timeout.
// tc is high while the count sits at LIMIT-1, so a wait window lasts exactly LIMIT cycles.
module sysid_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int unsigned W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] TC_VAL = W'(LIMIT - 1);

    logic [W-1:0] count_q, count_d;

    assign tc = (count_q == TC_VAL);

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (en && !tc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time sequencer: reads sysid word 0 (ID) and word 1 (timestamp), retries on timeout,
// and publishes sticky, registered match/timeout flags.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    sysid_boot_checker_if.master avm,
    output logic                 busy,
    output logic                 done,
    output logic                 id_ok,
    output logic                 ts_ok,
    output logic                 timeout_err,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]  state_q, state_d;
    logic        word_q, word_d;
    logic [3:0]  retry_q, retry_d;
    logic        boot_q, boot_d;
    logic        id_vld_q, id_vld_d;
    logic        ts_vld_q, ts_vld_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        tmo_q, tmo_d;
    logic [31:0] id_value_q, id_value_d;
    logic [31:0] ts_value_q, ts_value_d;

    logic ctr_load, ctr_en, ctr_tc;

    sysid_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock  (clock),
        .reset_n(reset_n),
        .load   (ctr_load),
        .en     (ctr_en),
        .tc     (ctr_tc)
    );

    assign avm.read    = (state_q == S_REQ);
    assign avm.address = word_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout_err = tmo_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        retry_d    = retry_q;
        boot_d     = boot_q;
        id_vld_d   = id_vld_q;
        ts_vld_d   = ts_vld_q;
        done_d     = done_q;
        id_ok_d    = id_ok_q;
        ts_ok_d    = ts_ok_q;
        tmo_d      = tmo_q;
        id_value_d = id_value_q;
        ts_value_d = ts_value_q;
        ctr_load   = 1'b0;
        ctr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // boot_q carries the one-shot automatic start out of reset.
                if (start || boot_q) begin
                    boot_d   = 1'b0;
                    word_d   = SYSID_WORD_ID;
                    retry_d  = '0;
                    done_d   = 1'b0;
                    id_ok_d  = 1'b0;
                    ts_ok_d  = 1'b0;
                    tmo_d    = 1'b0;
                    id_vld_d = 1'b0;
                    ts_vld_d = 1'b0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (!avm.waitrequest) begin
                    ctr_load = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                ctr_en = 1'b1;
                // Data beats the timeout when both land in the same cycle.
                if (avm.readdatavalid) begin
                    retry_d = '0;
                    if (word_q == SYSID_WORD_ID) begin
                        id_value_d = avm.readdata;
                        id_vld_d   = 1'b1;
                        word_d     = SYSID_WORD_TS;
                        state_d    = S_REQ;
                    end else begin
                        ts_value_d = avm.readdata;
                        ts_vld_d   = 1'b1;
                        state_d    = S_DONE;
                    end
                end else if (ctr_tc) begin
                    if (retry_q < 4'(MAX_RETRIES)) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_REQ;
                    end else begin
                        tmo_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                id_ok_d = word_ok(id_vld_q, id_value_q, EXPECTED_ID);
                ts_ok_d = word_ok(ts_vld_q, ts_value_q, EXPECTED_TS);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            word_q     <= SYSID_WORD_ID;
            retry_q    <= '0;
            boot_q     <= AUTO_START;
            id_vld_q   <= 1'b0;
            ts_vld_q   <= 1'b0;
            done_q     <= 1'b0;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
            tmo_q      <= 1'b0;
            id_value_q <= '0;
            ts_value_q <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            retry_q    <= retry_d;
            boot_q     <= boot_d;
            id_vld_q   <= id_vld_d;
            ts_vld_q   <= ts_vld_d;
            done_q     <= done_d;
            id_ok_q    <= id_ok_d;
            ts_ok_q    <= ts_ok_d;
            tmo_q      <= tmo_d;
            id_value_q <= id_value_d;
            ts_value_q <= ts_value_d;
        end
    end
endmodule

// File: tb/tb_sysid_boot_checker.sv
// Scoreboard bench for sysid_boot_checker: directed runs are queued with expected results,
// a monitor pops and compares on every rising edge of done.
module tb_sysid_boot_checker;
    localparam int          TMO     = 8;
    localparam int          RET     = 2;
    localparam logic [31:0] TS_GOOD = 32'h50FF_598A;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, id_ok, ts_ok, timeout_err;
    logic [31:0] id_value, ts_value;

    sysid_boot_checker_if bus();

    sysid_boot_checker #(
        .EXPECTED_ID   (32'h0000_0000),
        .EXPECTED_TS   (TS_GOOD),
        .TIMEOUT_CYCLES(TMO),
        .MAX_RETRIES   (RET),
        .AUTO_START    (1'b1)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .avm        (bus),
        .busy       (busy),
        .done       (done),
        .id_ok      (id_ok),
        .ts_ok      (ts_ok),
        .timeout_err(timeout_err),
        .id_value   (id_value),
        .ts_value   (ts_value)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] id_v;
        logic [31:0] ts_v;
        int          ts_reads;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   results_seen = 0;
    int   cyc = 0;

    // Slave model knobs
    int          w1_wait = 0;
    int          drop_left = 0;
    bit          stray = 1'b0;
    logic [31:0] ts_data = TS_GOOD;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_run(input logic eid, input logic ets, input logic etmo,
                              input logic [31:0] tsv, input int reads, input int lat);
        exp_t e;
        e.id_ok = eid; e.ts_ok = ets; e.tmo = etmo;
        e.id_v = 32'h0; e.ts_v = tsv; e.ts_reads = reads; e.lat = lat;
        sb.push_back(e);
    endtask

    // Avalon slave model, updated on the falling edge
    initial begin
        int          pend;
        int          wait_left;
        bit          in_req;
        logic [31:0] pend_data;
        pend = 0; wait_left = 0; in_req = 1'b0; pend_data = '0;
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        forever begin
            @(negedge clock);
            bus.readdatavalid = 1'b0;
            if (!reset_n) begin
                pend = 0; in_req = 1'b0; bus.waitrequest = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.readdatavalid = 1'b1;
                        bus.readdata      = pend_data;
                    end
                end
                if (bus.read) begin
                    if (!in_req) begin
                        in_req    = 1'b1;
                        wait_left = bus.address ? w1_wait : 0;
                    end
                    if (wait_left > 0) begin
                        bus.waitrequest = 1'b1;
                        wait_left--;
                    end else begin
                        bus.waitrequest = 1'b0;
                        in_req = 1'b0;
                        if (!bus.address) begin
                            pend = 1; pend_data = 32'h0000_0000;
                        end else if (drop_left > 0) begin
                            drop_left--;
                            if (stray) begin
                                pend = TMO + 1; pend_data = 32'hDEAD_BEEF;
                            end
                        end else begin
                            pend = 1; pend_data = ts_data;
                        end
                    end
                end else begin
                    bus.waitrequest = 1'b0;
                end
            end
        end
    end

    // Monitor and scoreboard
    initial begin
        logic pd, pb, prw, pa;
        int   bstart, reads;
        exp_t e;
        pd = 1'b0; pb = 1'b0; prw = 1'b0; pa = 1'b0; bstart = 0; reads = 0;
        forever begin
            @(negedge clock);
            #1;
            if (busy && !pb) begin
                bstart = cyc;
                reads  = 0;
            end
            if (prw) begin
                check("bp_read_held", bus.read, 1);
                check("bp_addr_held", bus.address, pa);
            end
            if (bus.read && !bus.waitrequest && bus.address) reads++;
            if (done && !pd) begin
                results_seen++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got=done-rise want=no-run-queued at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    check("id_ok", id_ok, e.id_ok);
                    check("ts_ok", ts_ok, e.ts_ok);
                    check("timeout_err", timeout_err, e.tmo);
                    check("id_value", id_value, e.id_v);
                    check("ts_value", ts_value, e.ts_v);
                    check("ts_reads", reads, e.ts_reads);
                    check("busy_cycles", cyc - bstart, e.lat);
                end
                $display("run %0d: id_ok=%0b ts_ok=%0b tmo=%0b id=%h ts=%h ts_reads=%0d busy_cycles=%0d",
                         results_seen, id_ok, ts_ok, timeout_err, id_value, ts_value, reads, cyc - bstart);
            end
            pd  = done;
            pb  = busy;
            prw = bus.read && bus.waitrequest;
            pa  = bus.address;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_results(input int target, input int limit, input string name);
        int n;
        n = 0;
        while (results_seen < target && n < limit) begin
            @(negedge clock);
            #2;
            n++;
        end
        check(name, results_seen, target);
    endtask

    initial begin
        bit found;
        start   = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        step(3);
        #1;
        check("rst_read", bus.read, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_id_ok", id_ok, 0);
        check("rst_ts_ok", ts_ok, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_id_value", id_value, 0);
        check("rst_ts_value", ts_value, 0);

        // Nominal boot via automatic start
        expect_run(1'b1, 1'b1, 1'b0, TS_GOOD, 1, 5);
        @(negedge clock);
        reset_n = 1'b1;
        wait_results(1, 60, "wait_nominal");
        step(3);

        // Timestamp mismatch
        ts_data = 32'h1234_5678;
        expect_run(1'b1, 1'b0, 1'b0, 32'h1234_5678, 1, 5);
        pulse_start();
        wait_results(2, 60, "wait_mismatch");
        step(3);

        // Backpressure on the word-1 read
        ts_data = TS_GOOD;
        w1_wait = 4;
        expect_run(1'b1, 1'b1, 1'b0, TS_GOOD, 1, 9);
        pulse_start();
        wait_results(3, 60, "wait_backpressure");
        w1_wait = 0;
        step(3);

        // Word 1 never answered: initial read plus RET retries, then error
        drop_left = 3;
        stray     = 1'b0;
        expect_run(1'b1, 1'b0, 1'b1, TS_GOOD, 3, 30);
        pulse_start();
        wait_results(4, 120, "wait_timeout");
        drop_left = 0;
        step(3);

        // Stray data one cycle after a timeout, plus a start while busy
        drop_left = 1;
        stray     = 1'b1;
        expect_run(1'b1, 1'b1, 1'b0, TS_GOOD, 2, 14);
        pulse_start();
        step(4);
        pulse_start();
        wait_results(5, 80, "wait_late_data");
        step(30);
        check("no_second_run", results_seen, 5);
        check("idle_after_run", busy, 0);
        stray     = 1'b0;
        drop_left = 0;

        // Reset during WAIT, then automatic restart
        expect_run(1'b1, 1'b1, 1'b0, TS_GOOD, 1, 5);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clock);
            #2;
            if (busy && !bus.read) found = 1'b1;
        end
        check("reach_wait", found, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_read", bus.read, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_ts_value", ts_value, 0);
        check("midrst_timeout_err", timeout_err, 0);
        step(2);
        @(negedge clock);
        reset_n = 1'b1;
        wait_results(6, 60, "wait_after_reset");
        step(5);
        check("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
